// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: CPU command encodings, arbiter
// state encoding and default bus widths.
package mem_arbiter_pkg;

  localparam int DEF_AW = 9;
  localparam int DEF_DW = 16;

  localparam logic [1:0] MREAD  = 2'b00;
  localparam logic [1:0] MNONE  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b11;
  localparam logic [1:0] MILL   = 2'b10;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // The illegal encoding is deliberately not an access, so it yields the RAM.
  function automatic logic is_cpu_access(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Saturating count of RUN cycles a loader request has been left waiting,
// plus the sticky-until-granted starvation flag.
module arb_wait_counter #(
  parameter int STARVE_LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic ld_starved
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count_q, count_d;
  logic          starved_q, starved_d;

  always_comb begin
    count_d   = count_q;
    starved_d = starved_q;
    if (!run || !ld_req || ld_gnt) begin
      count_d = '0;
    end else if (count_q < LIMIT) begin
      count_d = count_q + 1'b1;
    end
    // A grant always wins over reaching the limit in the same cycle.
    if (ld_gnt) begin
      starved_d = 1'b0;
    end else if (count_d == LIMIT) begin
      starved_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      starved_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      starved_q <= starved_d;
    end
  end

  assign ld_starved = starved_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port RAM between the CPU and the loader/debug port:
// the loader owns it during BOOT, afterwards the CPU has absolute priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter bit BOOT_EN      = 1'b1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_mem_cmd,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_reset,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_done,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_starved,
  output logic [AW-1:0] ld_count,
  output logic          err_cmd,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam arb_state_e RESET_STATE = BOOT_EN ? ST_BOOT : ST_RUN;

  arb_state_e    state_q, state_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_hold_q, rdata_hold_d;
  logic [AW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          in_boot, cpu_owns, gnt;

  assign in_boot  = (state_q == ST_BOOT);
  assign cpu_owns = !in_boot && is_cpu_access(cpu_mem_cmd);
  assign gnt      = ld_req && !cpu_owns;

  always_comb begin
    state_d      = state_q;
    rvalid_d     = gnt && !ld_we;
    rdata_hold_d = rdata_hold_q;
    count_d      = count_q;
    err_d        = err_q;
    if (rvalid_q) begin
      rdata_hold_d = ram_rdata;
    end
    if (in_boot) begin
      if (ld_done) begin
        state_d = ST_RUN;
      end
      if (gnt && ld_we && (count_q != '1)) begin
        count_d = count_q + 1'b1;
      end
    end else if (cpu_mem_cmd == MILL) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      rvalid_q     <= 1'b0;
      rdata_hold_q <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= rvalid_d;
      rdata_hold_q <= rdata_hold_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    ram_addr  = cpu_mem_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    if (cpu_owns) begin
      ram_we = (cpu_mem_cmd == MWRITE);
    end else if (gnt) begin
      ram_addr  = ld_addr;
      ram_we    = ld_we;
      ram_wdata = ld_wdata;
    end
  end

  arb_wait_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wait (
    .clk       (clk),
    .reset     (reset),
    .run       (!in_boot),
    .ld_req    (ld_req),
    .ld_gnt    (gnt),
    .ld_starved(ld_starved)
  );

  // Read data is live in the valid cycle and held afterwards until the next read.
  assign ld_rdata  = rvalid_q ? ram_rdata : rdata_hold_q;
  assign cpu_rdata = ram_rdata;
  assign cpu_reset = in_boot;
  assign ld_gnt    = gnt;
  assign ld_rvalid = rvalid_q;
  assign ld_count  = count_q;
  assign err_cmd   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cpu_mem_cmd;
  logic [AW-1:0] cpu_mem_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_reset;
  logic          ld_req, ld_we, ld_done;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt, ld_rvalid, ld_starved, err_cmd;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] ld_count;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  mem_arbiter #(
    .AW(AW), .DW(DW), .BOOT_EN(1'b1), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_reset(cpu_reset),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata), .ld_starved(ld_starved), .ld_count(ld_count),
    .err_cmd(err_cmd), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_set(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d;
  endtask

  task automatic boot_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_set(1'b1, 1'b1, a, d);
    #1;
    chk($sformatf("boot_gnt@%0d", a), 16'(ld_gnt), 16'h1);
    chk($sformatf("boot_ramaddr@%0d", a), 16'(ram_addr), 16'(a));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    cpu_mem_cmd = 2'b01; cpu_mem_addr = '0; cpu_wdata = '0;
    ld_done = 1'b0;
    ld_set(1'b0, 1'b0, '0, '0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_cpu_reset", 16'(cpu_reset), 16'h1);
    chk("rst_rvalid", 16'(ld_rvalid), 16'h0);
    chk("rst_starved", 16'(ld_starved), 16'h0);
    chk("rst_count", 16'(ld_count), 16'h0);
    chk("rst_err", 16'(err_cmd), 16'h0);

    // BOOT: CPU read command must be ignored.
    cpu_mem_cmd = 2'b00; cpu_mem_addr = 9'd3;
    boot_write(9'd0, 16'h1234);
    boot_write(9'd1, 16'hABCD);
    boot_write(9'd2, 16'hE000);
    chk("count_after3", 16'(ld_count), 16'd3);
    boot_write(9'd7, 16'h7777);
    boot_write(9'd30, 16'h3030);

    // ld_done together with a write: write still granted.
    ld_done = 1'b1;
    ld_set(1'b1, 1'b1, 9'd9, 16'h0042);
    #1;
    chk("done_gnt", 16'(ld_gnt), 16'h1);
    chk("done_ramwe", 16'(ram_we), 16'h1);
    chk("done_cpu_reset_before", 16'(cpu_reset), 16'h1);
    tick();
    ld_done = 1'b0;
    ld_set(1'b0, 1'b0, '0, '0);
    chk("done_cpu_reset_after", 16'(cpu_reset), 16'h0);
    chk("done_count", 16'(ld_count), 16'd6);
    chk("mem0", mem[0], 16'h1234);
    chk("mem1", mem[1], 16'hABCD);
    chk("mem2", mem[2], 16'hE000);
    chk("mem9", mem[9], 16'h0042);

    // CPU priority: CPU read @5 blocks loader read @7.
    cpu_mem_cmd = 2'b00; cpu_mem_addr = 9'd5;
    ld_set(1'b1, 1'b0, 9'd7, '0);
    #1;
    chk("prio_gnt0", 16'(ld_gnt), 16'h0);
    chk("prio_ramaddr5", 16'(ram_addr), 16'd5);
    tick();
    chk("prio_rvalid0", 16'(ld_rvalid), 16'h0);
    cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'd0;
    #1;
    chk("prio_gnt1", 16'(ld_gnt), 16'h1);
    chk("prio_ramaddr7", 16'(ram_addr), 16'd7);
    chk("prio_ramwe0", 16'(ram_we), 16'h0);
    tick();
    ld_set(1'b0, 1'b0, '0, '0);
    chk("prio_rvalid1", 16'(ld_rvalid), 16'h1);
    chk("prio_rdata", ld_rdata, 16'h7777);
    tick();
    chk("hold_rvalid0", 16'(ld_rvalid), 16'h0);
    chk("hold_rdata", ld_rdata, 16'h7777);
    chk("cpu_rdata_mem0", cpu_rdata, 16'h1234);

    // Back-to-back loader reads @0 then @1.
    ld_set(1'b1, 1'b0, 9'd0, '0);
    tick();
    ld_set(1'b1, 1'b0, 9'd1, '0);
    chk("b2b_rvalid_a", 16'(ld_rvalid), 16'h1);
    chk("b2b_rdata_a", ld_rdata, 16'h1234);
    tick();
    ld_set(1'b0, 1'b0, '0, '0);
    chk("b2b_rvalid_b", 16'(ld_rvalid), 16'h1);
    chk("b2b_rdata_b", ld_rdata, 16'hABCD);
    tick();

    // Starvation with limit 4 under continuous CPU reads.
    cpu_mem_cmd = 2'b00; cpu_mem_addr = 9'd2;
    ld_set(1'b1, 1'b1, 9'd20, 16'h5555);
    tick(); tick(); tick();
    chk("starve_after3", 16'(ld_starved), 16'h0);
    tick();
    chk("starve_after4", 16'(ld_starved), 16'h1);
    tick();
    chk("starve_held", 16'(ld_starved), 16'h1);
    cpu_mem_cmd = 2'b01;
    #1;
    chk("starve_gnt", 16'(ld_gnt), 16'h1);
    chk("starve_ramwe", 16'(ram_we), 16'h1);
    tick();
    ld_set(1'b0, 1'b0, '0, '0);
    chk("starve_clear", 16'(ld_starved), 16'h0);
    chk("mem20", mem[20], 16'h5555);
    chk("count_frozen", 16'(ld_count), 16'd6);

    // Illegal command: loader write granted, CPU write suppressed, sticky error.
    cpu_mem_cmd = 2'b10; cpu_mem_addr = 9'd30; cpu_wdata = 16'hDEAD;
    ld_set(1'b1, 1'b1, 9'd21, 16'h6666);
    #1;
    chk("ill_gnt", 16'(ld_gnt), 16'h1);
    chk("ill_ramaddr", 16'(ram_addr), 16'd21);
    chk("ill_ramwdata", ram_wdata, 16'h6666);
    tick();
    cpu_mem_cmd = 2'b01;
    ld_set(1'b0, 1'b0, '0, '0);
    chk("ill_err", 16'(err_cmd), 16'h1);
    tick();
    chk("ill_err_sticky", 16'(err_cmd), 16'h1);
    chk("mem21", mem[21], 16'h6666);
    chk("mem30_kept", mem[30], 16'h3030);

    // CPU write path.
    cpu_mem_cmd = 2'b11; cpu_mem_addr = 9'd22; cpu_wdata = 16'h2222;
    ld_set(1'b1, 1'b1, 9'd23, 16'h9999);
    #1;
    chk("cpuw_ramwe", 16'(ram_we), 16'h1);
    chk("cpuw_gnt0", 16'(ld_gnt), 16'h0);
    tick();
    cpu_mem_cmd = 2'b01;
    ld_set(1'b0, 1'b0, '0, '0);
    tick();
    chk("mem22", mem[22], 16'h2222);

    // Reset right after a granted loader read.
    ld_set(1'b1, 1'b0, 9'd0, '0);
    #1;
    chk("rr_gnt", 16'(ld_gnt), 16'h1);
    tick();
    ld_set(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    chk("rr_rvalid", 16'(ld_rvalid), 16'h0);
    chk("rr_cpu_reset", 16'(cpu_reset), 16'h1);
    chk("rr_count", 16'(ld_count), 16'h0);
    chk("rr_err", 16'(err_cmd), 16'h0);
    reset = 1'b0;
    cpu_mem_cmd = 2'b00;
    ld_set(1'b1, 1'b1, 9'd40, 16'h4040);
    #1;
    chk("rr_boot_gnt", 16'(ld_gnt), 16'h1);
    tick();
    ld_set(1'b0, 1'b0, '0, '0);
    chk("rr_boot_count", 16'(ld_count), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
